switch_pattern_seq: RTL
=======================

Name: switch_pattern_seq

Overview:
- Downstream consumer of the 8 MHz enable pulse (one-cycle strobe every 25 clk cycles at 200 MHz).
- Steps through a programmable photonic-switch pattern table, one table entry per tick or held for several ticks.
- Drives the switch control lines with a forced all-off blanking window after every pattern change, so two optical paths are never driven during a transition.
- Sits between the tick generator and the switch driver outputs.

Parameters:
- NSW, 4, number of switch control channels.
- DEPTH, 16, pattern table entries.
- AW, $clog2(DEPTH), table address width.
- HW, 4, hold-count field width.
- BLANK, 2, all-off clk cycles after each pattern change (0..20).

Ports:
- clk  in  1  system clock, 200 MHz.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle enable strobe from the 8 MHz generator.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  HW+NSW  table entry: {hold, sw}.
- last_addr  in  AW  final table index of the sequence.
- start  in  1  arm pulse.
- stop  in  1  abort pulse.
- trig  in  1  external trigger level; the sequence starts on its rising edge.
- sw_out  out  NSW  switch drive, registered.
- busy  out  1  high when not IDLE.
- step  out  AW  current table index.
- done  out  1  one-cycle pulse at sequence end.
- wr_rej  out  1  one-cycle pulse when a write is refused.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream): state IDLE; sw_out, step, done, wr_rej and busy all 0; hold counter 0; blank counter 0; trig history 0. Table contents are not reset.
- Table writes:
  - Accepted only in IDLE; the entry is readable the next cycle.
  - wr_en outside IDLE: write dropped, wr_rej pulses the next cycle.
- States:
  - IDLE -> ARMED on start.
  - ARMED -> WAIT on a trig rising edge (trig=1 now, 0 last cycle; registered history).
  - WAIT -> RUN on the next tick. Loads step=0 and hold_cnt=entry[0].hold, and starts blanking.
  - RUN: on each tick, if hold_cnt!=0, decrement hold_cnt. Otherwise:
    - if step==last_addr, go to IDLE and pulse done;
    - else step+1, reload hold_cnt from the new entry, start blanking.
  - Hold value h keeps an entry for h+1 ticks.
- stop in any state returns to IDLE the next cycle with sw_out=0. stop has priority over start, trig and tick in the same cycle.
- Output timing for a tick sampled in cycle t:
  - state and step update at t+1;
  - sw_out=0 for cycles t+1..t+BLANK;
  - new pattern on sw_out from t+BLANK+1;
  - with BLANK=0 the pattern appears at t+1.
- sw_out is 0 in IDLE, ARMED and WAIT.
- End of sequence: sw_out returns to 0 at t+1; done is high at t+1 only.
- A hold_cnt decrement with no step change causes no blanking.
- A tick arriving while blanking is processed normally. BLANK < 24 guarantees this never occurs with the 8 MHz source.
- A trig edge outside ARMED is ignored. start outside IDLE is ignored.
- last_addr is sampled continuously. Changing it while RUN is legal and takes effect at the next step compare.
- A step increment never exceeds DEPTH-1, since the compare is against last_addr. If last_addr >= DEPTH, the end is reached at DEPTH-1.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit).
  - At the end of the sequence with loop=1: step wraps to 0, hold_cnt reloads, blanking starts, state stays RUN, and done still pulses (once per pass).
  - With loop=0: behaves as single-shot.
- Undefined: no loop port; always single-shot.

Decomposition:
- Shared package photonic_seq_pkg:
  - state enum (IDLE, ARMED, WAIT, RUN);
  - HW and NSW defaults;
  - field-slice constants for the hold and sw portions of a table entry.
- One sub-module: seq_pattern_ram, a DEPTH x (HW+NSW) register array with synchronous write and combinational read. It is instantiated once.

Test Plan:
- Write entries 0..2 = {0,0001},{1,0010},{0,0100}, last_addr=2, BLANK=2, start, trig edge, tick every 25 clk.
  - sw_out goes 0001 at tick0+3, 0010 at tick1+3, holds 0010 through tick2 with no blank, 0100 at tick3+3.
  - done pulses at tick4+1 and sw_out=0 there.
- Assert stop mid-RUN with sw_out=0010 -> next cycle sw_out=0, busy=0, step frozen; a following start+trig runs again from step 0.
- Pulse wr_en while RUN -> wr_rej=1 one cycle later; the table entry is unchanged on re-read in IDLE.
- Assert start and stop in the same cycle in IDLE -> stays IDLE, busy=0.
- Hold trig high through start, with no edge -> remains ARMED, sw_out=0. A 0->1 trig edge then gives WAIT, and RUN at the next tick.
- With SEQ_LOOP_EN, loop=1, last_addr=1 -> step sequence 0,1,0,1; done pulses every 2 ticks; busy stays 1.
- With SEQ_LOOP_EN, setting loop=0 -> ends after the current pass.

Source files
------------

// File: rtl/switch_pattern_seq_pkg.sv
// Shared definitions for the photonic switch pattern sequencer.
// A table entry is packed as {hold, sw}; hold sits above the switch bits.
package photonic_seq_pkg;

    localparam int NSW_DEF = 4;
    localparam int HW_DEF  = 4;

    localparam int SW_LSB   = 0;
    localparam int SW_MSB   = NSW_DEF - 1;
    localparam int HOLD_LSB = NSW_DEF;
    localparam int HOLD_MSB = NSW_DEF + HW_DEF - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WAIT  = 2'd2,
        RUN   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/switch_pattern_seq_if.sv
// Bundle of control, table-write and switch-drive signals for the sequencer.
// The loop input only exists when SEQ_LOOP_EN is defined.
interface switch_pattern_seq_if #(
    parameter int NSW = 4,
    parameter int AW  = 4,
    parameter int HW  = 4
);
    logic               tick;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [HW+NSW-1:0]  wr_data;
    logic [AW-1:0]      last_addr;
    logic               start;
    logic               stop;
    logic               trig;
`ifdef SEQ_LOOP_EN
    logic               loop;
`endif
    logic [NSW-1:0]     sw_out;
    logic               busy;
    logic [AW-1:0]      step;
    logic               done;
    logic               wr_rej;

    modport master (
        output tick, wr_en, wr_addr, wr_data, last_addr, start, stop, trig,
`ifdef SEQ_LOOP_EN
        output loop,
`endif
        input  sw_out, busy, step, done, wr_rej
    );

    modport slave (
        input  tick, wr_en, wr_addr, wr_data, last_addr, start, stop, trig,
`ifdef SEQ_LOOP_EN
        input  loop,
`endif
        output sw_out, busy, step, done, wr_rej
    );

endinterface

// File: rtl/switch_pattern_seq_ram.sv
// Pattern table: register array with synchronous write and combinational read.
module seq_pattern_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Store an entry; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/switch_pattern_seq.sv
// Photonic switch pattern sequencer: steps through the pattern table on tick
// strobes, holds entries for hold+1 ticks, and blanks all switches for BLANK
// cycles after each pattern change. Optional macro SEQ_LOOP_EN adds a loop
// input that restarts the table instead of finishing.
module switch_pattern_seq
    import photonic_seq_pkg::*;
#(
    parameter int NSW   = NSW_DEF,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int HW    = HW_DEF,
    parameter int BLANK = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    switch_pattern_seq_if.slave  bus
);

    localparam int            DW       = HW + NSW;
    localparam int            BW       = 5;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    seq_state_e      r_state;
    seq_state_e      w_state_next;
    logic [AW-1:0]   r_step;
    logic [AW-1:0]   w_step_next;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_next;
    logic [BW-1:0]   r_blank_cnt;
    logic [BW-1:0]   w_blank_next;
    logic [NSW-1:0]  r_sw;
    logic [NSW-1:0]  w_sw_next;
    logic            r_trig_d;
    logic            r_done;
    logic            w_done_next;
    logic            r_wr_rej;
    logic            w_load;
    logic            w_dec;
    logic            w_loop;
    logic            w_trig_rise;
    logic            w_at_end;
    logic            w_we;
    logic [DW-1:0]   w_entry;

`ifdef SEQ_LOOP_EN
    assign w_loop = bus.loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_trig_rise = bus.trig & ~r_trig_d;
    assign w_at_end    = (r_step == bus.last_addr) || (r_step == LAST_IDX);
    assign w_we        = bus.wr_en && (r_state == IDLE);

    seq_pattern_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_raddr (w_step_next),
        .o_rdata (w_entry)
    );

    // Sequencing decisions: next state, next step, and whether to reload/decrement
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        if (bus.stop) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) w_state_next = ARMED;
                end
                ARMED: begin
                    if (w_trig_rise) w_state_next = WAIT;
                end
                WAIT: begin
                    if (bus.tick) begin
                        w_state_next = RUN;
                        w_step_next  = '0;
                        w_load       = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.tick) begin
                        if (r_hold_cnt != '0) begin
                            w_dec = 1'b1;
                        end else if (w_at_end) begin
                            w_done_next = 1'b1;
                            if (w_loop) begin
                                w_step_next = '0;
                                w_load      = 1'b1;
                            end else begin
                                w_state_next = IDLE;
                            end
                        end else begin
                            w_step_next = r_step + 1'b1;
                            w_load      = 1'b1;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Hold/blank counter updates and the next switch drive value
    always_comb begin
        w_hold_next  = r_hold_cnt;
        w_blank_next = (r_blank_cnt != '0) ? r_blank_cnt - 1'b1 : '0;
        if (w_load) begin
            w_hold_next  = w_entry[NSW +: HW];
            w_blank_next = BW'(BLANK);
        end else if (w_dec) begin
            w_hold_next = r_hold_cnt - 1'b1;
        end
        w_sw_next = '0;
        if ((w_state_next == RUN) && (w_blank_next == '0)) begin
            w_sw_next = w_entry[NSW-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: step, counters, trigger history and output strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step      <= '0;
            r_hold_cnt  <= '0;
            r_blank_cnt <= '0;
            r_sw        <= '0;
            r_trig_d    <= 1'b0;
            r_done      <= 1'b0;
            r_wr_rej    <= 1'b0;
        end else begin
            r_step      <= w_step_next;
            r_hold_cnt  <= w_hold_next;
            r_blank_cnt <= w_blank_next;
            r_sw        <= w_sw_next;
            r_trig_d    <= bus.trig;
            r_done      <= w_done_next;
            r_wr_rej    <= bus.wr_en && (r_state != IDLE);
        end
    end

    assign bus.sw_out = r_sw;
    assign bus.busy   = (r_state != IDLE);
    assign bus.step   = r_step;
    assign bus.done   = r_done;
    assign bus.wr_rej = r_wr_rej;

endmodule
